// File: rtl/gpio_stretcher.sv
// Output GPIO stretcher: drives a pad bank and enforces a programmable minimum hold per bit.
// Define GPIO_STRETCHER_READBACK_EN to add synchronised pad readback (raw_data) and contention flags (mismatch).
module gpio_stretcher #(
    parameter int DATA_WIDTH = 8,
    parameter int CNTR_WIDTH = 22
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_hold,
    input  logic [DATA_WIDTH-1:0] out_data,
    input  logic [DATA_WIDTH-1:0] out_tri,
    inout  wire  [DATA_WIDTH-1:0] gpio_data,
    output logic [DATA_WIDTH-1:0] held_data,
`ifdef GPIO_STRETCHER_READBACK_EN
    output logic [DATA_WIDTH-1:0] raw_data,
    output logic [DATA_WIDTH-1:0] mismatch,
`endif
    output logic [DATA_WIDTH-1:0] busy
);

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tri_q, tri_d;
    logic [CNTR_WIDTH-1:0] cnt_q [DATA_WIDTH];
    logic [CNTR_WIDTH-1:0] cnt_d [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] busy_w;

    always_comb begin
        hold_d = hold_q;
        tri_d  = out_tri;
        busy_w = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            cnt_d[j]  = cnt_q[j];
            busy_w[j] = (cnt_q[j] != '0);
            // A running hold freezes the level; requests are re-evaluated once it expires.
            if (busy_w[j]) begin
                cnt_d[j] = cnt_q[j] - 1'b1;
            end else if (out_data[j] != hold_q[j]) begin
                hold_d[j] = out_data[j];
                cnt_d[j]  = cfg_hold;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_q <= '0;
            tri_q  <= '1;
            for (int j = 0; j < DATA_WIDTH; j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            hold_q <= hold_d;
            tri_q  <= tri_d;
            for (int j = 0; j < DATA_WIDTH; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_iobuf
        assign gpio_data[j] = tri_q[j] ? 1'bz : hold_q[j];
    end

    assign held_data = hold_q;
    assign busy      = busy_w;

`ifdef GPIO_STRETCHER_READBACK_EN
    logic [DATA_WIDTH-1:0] raw_meta_q, raw_meta_d;
    logic [DATA_WIDTH-1:0] raw_q, raw_d;
    logic [DATA_WIDTH-1:0] mismatch_q, mismatch_d;

    always_comb begin
        raw_meta_d = gpio_data;
        raw_d      = raw_meta_q;
        // Only a driven, settled pad can be said to fight an external driver.
        mismatch_d = ~tri_q & ~busy_w & (raw_q ^ hold_q);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            raw_meta_q <= '0;
            raw_q      <= '0;
            mismatch_q <= '0;
        end else begin
            raw_meta_q <= raw_meta_d;
            raw_q      <= raw_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign raw_data = raw_q;
    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_gpio_stretcher.sv
// Bench for gpio_stretcher: time-based reference model compared every cycle plus directed literal checks.
module tb_gpio_stretcher;

    logic        clk;
    logic        areset;
    logic [21:0] cfg_hold;
    logic [7:0]  out_data;
    logic [7:0]  out_tri;
    wire  [7:0]  gpio;
    logic [7:0]  held_data;
    logic [7:0]  busy;
`ifdef GPIO_STRETCHER_READBACK_EN
    logic [7:0]  raw_data;
    logic [7:0]  mismatch;
`endif

    gpio_stretcher #(.DATA_WIDTH(8), .CNTR_WIDTH(22)) dut (
        .aclk      (clk),
        .areset    (areset),
        .cfg_hold  (cfg_hold),
        .out_data  (out_data),
        .out_tri   (out_tri),
        .gpio_data (gpio),
        .held_data (held_data),
`ifdef GPIO_STRETCHER_READBACK_EN
        .raw_data  (raw_data),
        .mismatch  (mismatch),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit may take a new level only once cfg_hold+1 edges have
    // passed since its last update; busy spans the edges in between.
    longint    ecnt = 0;
    longint    next_ok [8];
    bit [7:0]  m_h;
    bit [7:0]  m_t;
    bit        started = 1'b0;

    always @(posedge clk) begin
        ecnt    <= ecnt + 1;
        started <= 1'b1;
        if (areset) begin
            m_h <= '0;
            m_t <= '1;
            for (int j = 0; j < 8; j++) next_ok[j] <= 0;
        end else begin
            m_t <= out_tri;
            for (int j = 0; j < 8; j++) begin
                if (ecnt >= next_ok[j] && out_data[j] != m_h[j]) begin
                    m_h[j]     <= out_data[j];
                    next_ok[j] <= ecnt + longint'(cfg_hold) + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [7:0] eb;
            logic [7:0] drv;
            for (int j = 0; j < 8; j++) eb[j] = (ecnt < next_ok[j]);
            drv = ~m_t;
            chk("model_held", {24'd0, held_data}, {24'd0, m_h});
            chk("model_busy", {24'd0, busy}, {24'd0, eb});
            chk("model_pads", {24'd0, gpio & drv}, {24'd0, m_h & drv});
        end
    end

    bit eh1 [6] = '{1, 1, 1, 1, 1, 0};
    bit eb1 [6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        areset   = 1'b1;
        out_data = 8'hFF;
        out_tri  = 8'h00;
        cfg_hold = '0;
        repeat (3) @(negedge clk);
        chk("rst_held", {24'd0, held_data}, 32'h00);
        chk("rst_busy", {24'd0, busy}, 32'h00);
        areset = 1'b0;
        @(negedge clk);
        chk("rel_held", {24'd0, held_data}, 32'hFF);
        chk("rel_pads", {24'd0, gpio}, 32'hFF);
        chk("rel_busy", {24'd0, busy}, 32'h00);

        // Zero hold: bit 0 follows every toggle one cycle later.
        for (int i = 0; i < 8; i++) begin
            out_data[0] = ~out_data[0];
            @(negedge clk);
            chk("tog_h0", {31'd0, held_data[0]}, {31'd0, out_data[0]});
            chk("tog_b0", {31'd0, busy[0]}, 32'd0);
        end
        out_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("clr_held", {24'd0, held_data}, 32'h00);

        // Hold of 4: a 1-cycle pulse on bit 1 is stretched to 5 cycles.
        cfg_hold    = 22'd4;
        out_data[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("str_h1", {31'd0, held_data[1]}, {31'd0, eh1[i]});
            chk("str_b1", {31'd0, busy[1]}, {31'd0, eb1[i]});
            if (i == 0) out_data[1] = 1'b0;
        end
        repeat (6) @(negedge clk);

        // A glitch back to the held level inside the window leaves no trace.
        out_data[2] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("glt_h2", {31'd0, held_data[2]}, 32'd1);
            chk("glt_b2", {31'd0, busy[2]}, (i < 4) ? 32'd1 : 32'd0);
            if (i == 0) out_data[2] = 1'b0;
            if (i == 2) out_data[2] = 1'b1;
        end

        // Long hold interrupted by reset halfway through.
        cfg_hold    = 22'd100;
        out_data    = 8'h08;
        @(negedge clk);
        chk("lng_held", {24'd0, held_data}, 32'h08);
        cfg_hold = 22'd3;
        repeat (50) @(negedge clk);
        chk("lng_busy", {24'd0, busy}, 32'h0C);
        areset = 1'b1;
        @(negedge clk);
        chk("mid_rst_held", {24'd0, held_data}, 32'h00);
        chk("mid_rst_busy", {24'd0, busy}, 32'h00);
        areset = 1'b0;
        @(negedge clk);
        chk("post_held", {24'd0, held_data}, 32'h08);
        chk("post_busy", {24'd0, busy}, 32'h08);
        repeat (6) @(negedge clk);
        chk("post_idle", {24'd0, busy}, 32'h00);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
